// File: rtl/bin_collector_if.sv
// bin_collector_if: bin write strobe and frame stream handshake between CORDIC, collector and IFFT.
interface bin_collector_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              bin_valid;
  logic [WIDTH-1:0]  bin_data;
  logic [ADDR_W-1:0] bin_index;
  logic              ifft_ready;
  logic              ifft_valid;
  logic [WIDTH-1:0]  ifft_data;
  logic [ADDR_W-1:0] ifft_index;
  logic              ifft_last;
  logic              overflow;
  logic [7:0]        frame_count;
  modport master (
    output bin_valid, bin_data, bin_index, ifft_ready,
    input  ifft_valid, ifft_data, ifft_index, ifft_last, overflow, frame_count
  );
  modport slave (
    input  bin_valid, bin_data, bin_index, ifft_ready,
    output ifft_valid, ifft_data, ifft_index, ifft_last, overflow, frame_count
  );
endinterface

// File: rtl/bin_collector.sv
// bin_collector: ping-pong 64-bin frame assembler streaming complete frames in bin order.
module bin_collector #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input logic            clk_cal,
  input logic            rst,
  bin_collector_if.slave bus
);
  localparam int NBINS = 2 ** ADDR_W;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAIN} bank_t;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} rd_t;
  logic [WIDTH-1:0]  mem [2][NBINS];
  logic [NBINS-1:0]  mask [2];
  bank_t             bank_st [2];
  rd_t               st;
  logic              wr_bank, rd_bank, oth, wr_ok, complete, drain_done, pick;
  logic [NBINS-1:0]  mask_new;
  logic [ADDR_W-1:0] nxt;
  always_comb begin
    oth        = ~wr_bank;
    wr_ok      = bus.bin_valid && bank_st[wr_bank] == FILLING;
    mask_new   = mask[wr_bank] | (NBINS'(1) << bus.bin_index);
    complete   = wr_ok && &mask_new;
    drain_done = st == STREAM && bus.ifft_ready && bus.ifft_last;
    pick       = bank_st[oth] == FULL ? oth : wr_bank;
    nxt        = bus.ifft_index + ADDR_W'(1);
  end
  always_ff @(posedge clk_cal)
    if (wr_ok && !rst) mem[wr_bank][bus.bin_index] <= bus.bin_data;
  always_ff @(posedge clk_cal) begin
    if (rst) begin
      mask[0]         <= '0;
      mask[1]         <= '0;
      bank_st[0]      <= FILLING;
      bank_st[1]      <= EMPTY;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      st              <= IDLE;
      bus.ifft_valid  <= 1'b0;
      bus.ifft_data   <= '0;
      bus.ifft_index  <= '0;
      bus.ifft_last   <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.frame_count <= '0;
    end else begin
      bus.overflow <= bus.bin_valid && !wr_ok;
      if (wr_ok) mask[wr_bank] <= complete ? '0 : mask_new;
      if (complete) begin
        bank_st[wr_bank] <= FULL;
        if (bank_st[oth] == EMPTY) begin
          bank_st[oth] <= FILLING;
          wr_bank      <= oth;
        end
      end
      case (st)
        IDLE:
          if (bank_st[0] == FULL || bank_st[1] == FULL) begin
            bank_st[pick] <= DRAIN;
            rd_bank       <= pick;
            st            <= LOAD;
          end
        LOAD: begin
          bus.ifft_valid <= 1'b1;
          bus.ifft_data  <= mem[rd_bank][0];
          bus.ifft_index <= '0;
          bus.ifft_last  <= 1'b0;
          st             <= STREAM;
        end
        STREAM:
          if (drain_done) begin
            bus.ifft_valid  <= 1'b0;
            bus.ifft_last   <= 1'b0;
            bus.frame_count <= bus.frame_count + 8'd1;
            st              <= IDLE;
            // the freed bank takes over filling unless the other bank is still filling after this edge
            if (wr_bank != rd_bank && bank_st[wr_bank] == FILLING && !complete)
              bank_st[rd_bank] <= EMPTY;
            else begin
              bank_st[rd_bank] <= FILLING;
              wr_bank          <= rd_bank;
            end
          end else if (bus.ifft_ready) begin
            bus.ifft_data  <= mem[rd_bank][nxt];
            bus.ifft_index <= nxt;
            bus.ifft_last  <= &nxt;
          end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_collector.sv
// tb_bin_collector: directed scenarios for frame assembly, ordering, backpressure, overflow and reset.
module tb_bin_collector;
  logic clk_cal = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, ovf_cnt = 0;
  logic [38:0] q[$];
  logic [38:0] held_v, got, want;
  logic held = 1'b0;

  bin_collector_if #(.WIDTH(32), .ADDR_W(6)) bus ();
  bin_collector #(.WIDTH(32), .ADDR_W(6)) dut (.clk_cal(clk_cal), .rst(rst), .bus(bus));

  always #5 clk_cal = ~clk_cal;

  always @(negedge clk_cal) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        total++;
        if ({bus.ifft_last, bus.ifft_index, bus.ifft_data} !== held_v) begin
          bad++;
          $display("FAIL hold_stable: got %h want %h", {bus.ifft_last, bus.ifft_index, bus.ifft_data}, held_v);
        end
      end
      if (bus.ifft_valid && bus.ifft_ready) q.push_back({bus.ifft_last, bus.ifft_index, bus.ifft_data});
      if (bus.overflow) ovf_cnt++;
      held = bus.ifft_valid && !bus.ifft_ready;
      held_v = {bus.ifft_last, bus.ifft_index, bus.ifft_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task tick;
    @(posedge clk_cal);
    #1;
  endtask

  task wr(input int idx, input logic [31:0] d);
    bus.bin_valid = 1'b1;
    bus.bin_index = 6'(idx);
    bus.bin_data  = d;
    tick;
    bus.bin_valid = 1'b0;
  endtask

  task do_reset;
    rst = 1'b1;
    bus.bin_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    q.delete();
    ovf_cnt = 0;
  endtask

  task wait_q(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 1000) begin
      tick;
      t++;
    end
    repeat (4) tick;
  endtask

  task test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    got = {bus.ifft_valid, bus.ifft_last, bus.overflow, bus.ifft_index, bus.ifft_data};
    if (got !== '0 || bus.frame_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: got %h fc=%0d want 0 fc=0", got, bus.frame_count);
    end
    rst = 1'b0;
  endtask

  task test_basic;
    do_reset;
    bus.ifft_ready = 1'b1;
    for (int i = 0; i < 64; i++) wr(i, {16'(i), 16'(-i)});
    total++;
    if (bus.ifft_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e0: got %b want 0", bus.ifft_valid); end
    tick;
    total++;
    if (bus.ifft_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_e1: got %b want 0", bus.ifft_valid); end
    tick;
    total++;
    got = {bus.ifft_valid, bus.ifft_index, bus.ifft_data};
    if (got !== {1'b1, 6'd0, 32'd0}) begin bad++; $display("FAIL basic_first: got %h want %h", got, {1'b1, 6'd0, 32'd0}); end
    wait_q(64);
    total++;
    if (q.size() != 64) begin bad++; $display("FAIL basic_count: got %0d want 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      want = {i == 63, 6'(i), 16'(i), 16'(-i)};
      got = i < q.size() ? q[i] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL basic_bin%0d: got %h want %h", i, got, want); end
    end
    total++;
    if (bus.frame_count !== 8'd1) begin bad++; $display("FAIL basic_fc: got %0d want 1", bus.frame_count); end
  endtask

  task test_shuffle;
    int idx;
    do_reset;
    bus.ifft_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      idx = 63 - ((i * 5) % 64);
      wr(idx, {16'(idx), 16'(-idx)});
      if (idx == 5) wr(5, 32'h00050005);
    end
    wait_q(64);
    total++;
    if (q.size() != 64) begin bad++; $display("FAIL shuffle_count: got %0d want 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      want = {i == 63, 6'(i), (i == 5) ? 32'h00050005 : {16'(i), 16'(-i)}};
      got = i < q.size() ? q[i] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL shuffle_bin%0d: got %h want %h", i, got, want); end
    end
    total++;
    if (ovf_cnt != 0 || bus.frame_count !== 8'd1) begin
      bad++;
      $display("FAIL shuffle_ovf_fc: got ovf=%0d fc=%0d want 0 1", ovf_cnt, bus.frame_count);
    end
  endtask

  task test_toggle;
    int n, t;
    do_reset;
    bus.ifft_ready = 1'b0;
    for (int i = 0; i < 64; i++) wr(i, 32'hC0DE0000 + 32'(i));
    t = 0;
    while (!bus.ifft_valid && t < 10) begin tick; t++; end
    n = 0;
    while (bus.ifft_valid && n < 300) begin
      bus.ifft_ready = n[0];
      tick;
      n++;
    end
    bus.ifft_ready = 1'b1;
    total++;
    if (n != 128) begin bad++; $display("FAIL toggle_cycles: got %0d want 128", n); end
    total++;
    if (q.size() != 64) begin bad++; $display("FAIL toggle_count: got %0d want 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      want = {i == 63, 6'(i), 32'hC0DE0000 + 32'(i)};
      got = i < q.size() ? q[i] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL toggle_bin%0d: got %h want %h", i, got, want); end
    end
  endtask

  task test_overflow;
    do_reset;
    bus.ifft_ready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 64; i++) wr(i, {8'(f + 1), 18'd0, 6'(i)});
    tick;
    tick;
    total++;
    if (ovf_cnt != 64) begin bad++; $display("FAIL ovf_pulses: got %0d want 64", ovf_cnt); end
    total++;
    got = {bus.ifft_valid, bus.ifft_index, bus.ifft_data};
    if (got !== {1'b1, 6'd0, 32'h01000000} || bus.frame_count !== 8'd0) begin
      bad++;
      $display("FAIL ovf_stalled: got %h fc=%0d want %h fc=0", got, bus.frame_count, {1'b1, 6'd0, 32'h01000000});
    end
    bus.ifft_ready = 1'b1;
    wait_q(128);
    total++;
    if (q.size() != 128) begin bad++; $display("FAIL ovf_count: got %0d want 128", q.size()); end
    for (int j = 0; j < 128; j++) begin
      want = {(j % 64) == 63, 6'(j % 64), 8'(j / 64 + 1), 18'd0, 6'(j % 64)};
      got = j < q.size() ? q[j] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL ovf_bin%0d: got %h want %h", j, got, want); end
    end
    total++;
    if (bus.frame_count !== 8'd2 || ovf_cnt != 64) begin
      bad++;
      $display("FAIL ovf_fc: got fc=%0d ovf=%0d want 2 64", bus.frame_count, ovf_cnt);
    end
  endtask

  task test_reset_mid;
    int t;
    do_reset;
    bus.ifft_ready = 1'b1;
    for (int i = 0; i < 30; i++) wr(i, 32'hDEAD0000 + 32'(i));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({bus.ifft_valid, bus.overflow, bus.frame_count} !== 10'd0) begin
      bad++;
      $display("FAIL rstfill_out: got v=%b o=%b fc=%0d want 0", bus.ifft_valid, bus.overflow, bus.frame_count);
    end
    for (int i = 30; i < 64; i++) wr(i, 32'h77000000 + 32'(i));
    repeat (5) tick;
    total++;
    if (bus.ifft_valid !== 1'b0) begin bad++; $display("FAIL rstfill_stale: got valid %b want 0", bus.ifft_valid); end
    for (int i = 0; i < 30; i++) wr(i, 32'h77000000 + 32'(i));
    wait_q(64);
    total++;
    if (q.size() != 64) begin bad++; $display("FAIL rstfill_count: got %0d want 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      want = {i == 63, 6'(i), 32'h77000000 + 32'(i)};
      got = i < q.size() ? q[i] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL rstfill_bin%0d: got %h want %h", i, got, want); end
    end
    total++;
    if (bus.frame_count !== 8'd1) begin bad++; $display("FAIL rstfill_fc: got %0d want 1", bus.frame_count); end

    do_reset;
    for (int i = 0; i < 64; i++) wr(i, 32'h88000000 + 32'(i));
    t = 0;
    while (!(bus.ifft_valid && bus.ifft_index == 6'd20) && t < 200) begin tick; t++; end
    total++;
    if (t >= 200) begin bad++; $display("FAIL rststream_reach: got timeout want bin 20"); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    total++;
    got = {bus.ifft_valid, bus.ifft_last, bus.ifft_index, bus.ifft_data};
    if (got !== '0 || bus.frame_count !== 8'd0) begin
      bad++;
      $display("FAIL rststream_out: got %h fc=%0d want 0 fc=0", got, bus.frame_count);
    end
    repeat (80) tick;
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rststream_stale: got %0d samples want 0", q.size()); end
    for (int i = 0; i < 64; i++) wr(i, 32'h99000000 + 32'(i));
    wait_q(64);
    total++;
    if (q.size() != 64) begin bad++; $display("FAIL rststream_count: got %0d want 64", q.size()); end
    for (int i = 0; i < 64; i++) begin
      want = {i == 63, 6'(i), 32'h99000000 + 32'(i)};
      got = i < q.size() ? q[i] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL rststream_bin%0d: got %h want %h", i, got, want); end
    end
    total++;
    if (bus.frame_count !== 8'd1) begin bad++; $display("FAIL rststream_fc: got %0d want 1", bus.frame_count); end
  endtask

  task test_back_to_back;
    do_reset;
    bus.ifft_ready = 1'b1;
    for (int i = 0; i < 64; i++) wr(i, 32'hAA000000 + 32'(i));
    tick;
    tick;
    for (int i = 0; i < 64; i++) wr(i, 32'hBB000000 + 32'(i));
    total++;
    if (bus.ifft_valid !== 1'b0 || bus.frame_count !== 8'd1) begin
      bad++;
      $display("FAIL b2b_gap: got v=%b fc=%0d want 0 1", bus.ifft_valid, bus.frame_count);
    end
    tick;
    total++;
    if (bus.ifft_valid !== 1'b0) begin bad++; $display("FAIL b2b_load: got valid %b want 0", bus.ifft_valid); end
    tick;
    total++;
    got = {bus.ifft_valid, bus.ifft_index, bus.ifft_data};
    if (got !== {1'b1, 6'd0, 32'hBB000000}) begin bad++; $display("FAIL b2b_first: got %h want %h", got, {1'b1, 6'd0, 32'hBB000000}); end
    wait_q(128);
    total++;
    if (q.size() != 128) begin bad++; $display("FAIL b2b_count: got %0d want 128", q.size()); end
    for (int j = 0; j < 128; j++) begin
      want = {(j % 64) == 63, 6'(j % 64), (j < 64 ? 32'hAA000000 : 32'hBB000000) + 32'(j % 64)};
      got = j < q.size() ? q[j] : 'x;
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_bin%0d: got %h want %h", j, got, want); end
    end
    total++;
    if (ovf_cnt != 0 || bus.frame_count !== 8'd2) begin
      bad++;
      $display("FAIL b2b_ovf_fc: got ovf=%0d fc=%0d want 0 2", ovf_cnt, bus.frame_count);
    end
  endtask

  initial begin
    bus.bin_valid  = 1'b0;
    bus.bin_data   = '0;
    bus.bin_index  = '0;
    bus.ifft_ready = 1'b0;
    test_reset;
    test_basic;
    test_shuffle;
    test_toggle;
    test_overflow;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
